// File: rtl/wave_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wave_capture: zero-crossing triggered 256-sample capture into the half   |
// | of a double-buffered wave RAM that the display is not reading.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wave_capture #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic        read_index_q, read_index_d;
  logic        prev_msb_q, prev_msb_d;
  logic        write_enable_q, write_enable_d;
  logic [8:0]  write_address_q, write_address_d;
  logic [7:0]  write_sample_q, write_sample_d;

  logic [7:0]  sample_top;
  logic [7:0]  sample_conv;
  logic        sample_msb;
  logic        crossing;

  // Only the top byte reaches the RAM; the low bits are deliberately dropped.
  if (SAMPLE_W > 8) begin : g_low_bits
    logic unused_low_bits;
    assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];
  end

  assign sample_top  = new_sample_in[SAMPLE_W-1 -: 8];
  assign sample_msb  = new_sample_in[SAMPLE_W-1];
  assign sample_conv = {~sample_top[7], sample_top[6:0]};
  assign crossing    = new_sample_ready & prev_msb_q & ~sample_msb;

  always_comb begin
    state_d         = state_q;
    index_d         = index_q;
    read_index_d    = read_index_q;
    prev_msb_d      = prev_msb_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_sample_d  = write_sample_q;

    if (new_sample_ready) begin
      prev_msb_d = sample_msb;
    end

    case (state_q)
      ARMED: begin
        if (crossing) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, 8'd0};
          write_sample_d  = sample_conv;
          index_d         = 8'd1;
          state_d         = ACTIVE;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          write_enable_d  = 1'b1;
          write_address_d = {~read_index_q, index_q};
          write_sample_d  = sample_conv;
          index_d         = index_q + 8'd1;
          if (index_q == 8'd255) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Swap halves only while the display is guaranteed not to be reading.
        if (wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ARMED;
      index_q         <= 8'd0;
      read_index_q    <= 1'b0;
      prev_msb_q      <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= 9'd0;
      write_sample_q  <= 8'd0;
    end else begin
      state_q         <= state_d;
      index_q         <= index_d;
      read_index_q    <= read_index_d;
      prev_msb_q      <= prev_msb_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_sample_q  <= write_sample_d;
    end
  end

  assign write_address = write_address_q;
  assign write_enable  = write_enable_q;
  assign write_sample  = write_sample_q;
  assign read_index    = read_index_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wave_capture: directed vector bench for wave_capture.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int pass_cnt;
  int total_cnt;
  int writes;

  wave_capture #(.SAMPLE_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [15:0] smp;
    logic        idle;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_data;
    logic        exp_ri;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive inputs, take one clock edge, then sample outputs 1ns later.
  task automatic cycle(input logic rdy, input logic [15:0] smp, input logic idle);
    new_sample_ready  = rdy;
    new_sample_in     = smp;
    wave_display_idle = idle;
    @(posedge clk);
    #1;
    if (write_enable === 1'b1) writes++;
  endtask

  task automatic expect_write(input string name, input logic [8:0] addr, input logic [7:0] data);
    check({name, " we"}, {31'd0, write_enable}, 32'd1);
    check({name, " addr"}, {23'd0, write_address}, {23'd0, addr});
    check({name, " data"}, {24'd0, write_sample}, {24'd0, data});
  endtask

  initial begin
    logic [7:0] k8;
    pass_cnt = 0;
    total_cnt = 0;
    writes = 0;
    reset = 1'b1;
    new_sample_ready = 1'b0;
    new_sample_in = 16'h0000;
    wave_display_idle = 1'b0;

    vecs[0] = '{1'b1, 16'h0100, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 16'h8000, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 16'hC000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 16'h0010, 1'b0, 1'b1, 9'h100, 8'h80, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 9'h100, 8'h80, 1'b0};

    cycle(1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    check("reset we", {31'd0, write_enable}, 32'd0);
    check("reset addr", {23'd0, write_address}, 32'd0);
    check("reset data", {24'd0, write_sample}, 32'd0);
    check("reset read_index", {31'd0, read_index}, 32'd0);
    reset = 1'b0;

    // Trigger detection
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].rdy, vecs[i].smp, vecs[i].idle);
      check($sformatf("vec%0d we", i), {31'd0, write_enable}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d addr", i), {23'd0, write_address}, {23'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d data", i), {24'd0, write_sample}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d read_index", i), {31'd0, read_index}, {31'd0, vecs[i].exp_ri});
    end

    // Full capture: ramp 0x0100*k fills the upper half
    for (int k = 1; k < 256; k++) begin
      k8 = k[7:0];
      cycle(1'b1, {k8, 8'h00}, 1'b1);
      expect_write($sformatf("ramp%0d", k), {1'b1, k8}, k8 ^ 8'h80);
    end
    check("capture1 write count", writes, 256);

    // WAIT: strobes with a crossing are ignored
    cycle(1'b1, 16'h8000, 1'b0);
    cycle(1'b1, 16'h0100, 1'b0);
    cycle(1'b1, 16'h8000, 1'b0);
    cycle(1'b1, 16'h1000, 1'b0);
    check("wait writes", writes, 256);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0000, 1'b0);
      check("wait read_index", {31'd0, read_index}, 32'd0);
    end
    check("wait no write", writes, 256);

    // Swap; the strobe on the swap edge is not written but arms prev_msb
    cycle(1'b1, 16'h8000, 1'b1);
    check("swap read_index", {31'd0, read_index}, 32'd1);
    check("swap cycle we", {31'd0, write_enable}, 32'd0);
    writes = 0;
    cycle(1'b1, 16'h0020, 1'b0);
    expect_write("cap2 idx0", 9'h000, 8'h80);

    // Extremes
    cycle(1'b1, 16'h7FFF, 1'b0);
    expect_write("ext 7fff", 9'h001, 8'hFF);
    cycle(1'b1, 16'h8000, 1'b0);
    expect_write("ext 8000", 9'h002, 8'h00);
    cycle(1'b1, 16'hFF00, 1'b0);
    expect_write("ext ff00", 9'h003, 8'h7F);
    for (int k = 4; k < 256; k++) begin
      k8 = k[7:0];
      cycle(1'b1, 16'h0000, 1'b0);
      expect_write($sformatf("cap2 idx%0d", k), {1'b0, k8}, 8'h80);
    end
    check("capture2 write count", writes, 256);
    cycle(1'b1, 16'h8000, 1'b0);
    check("capture2 wait we", {31'd0, write_enable}, 32'd0);

    // Back-to-back strobes, alternating sign
    cycle(1'b0, 16'h0000, 1'b1);
    check("swap2 read_index", {31'd0, read_index}, 32'd0);
    writes = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, (i % 2 == 0) ? 16'hC000 : 16'h4000, 1'b0);
      if (i >= 1 && i <= 256) begin
        k8 = 8'(i - 1);
        expect_write($sformatf("b2b %0d", i), {1'b1, k8}, (i % 2 == 0) ? 8'h40 : 8'hC0);
      end else begin
        check($sformatf("b2b %0d idle we", i), {31'd0, write_enable}, 32'd0);
      end
    end
    check("b2b write count", writes, 256);

    // Reset mid-capture after 100 writes
    cycle(1'b0, 16'h0000, 1'b1);
    check("swap3 read_index", {31'd0, read_index}, 32'd1);
    cycle(1'b1, 16'h8000, 1'b0);
    writes = 0;
    for (int i = 0; i < 100; i++) begin
      k8 = i[7:0];
      cycle(1'b1, 16'h0100, 1'b0);
      expect_write($sformatf("pre-reset %0d", i), {1'b0, k8}, 8'h81);
    end
    check("pre-reset count", writes, 100);
    reset = 1'b1;
    cycle(1'b1, 16'h0100, 1'b1);
    reset = 1'b0;
    check("midreset we", {31'd0, write_enable}, 32'd0);
    check("midreset read_index", {31'd0, read_index}, 32'd0);
    check("midreset addr", {23'd0, write_address}, 32'd0);
    writes = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0100, 1'b0);
    cycle(1'b1, 16'h8000, 1'b0);
    check("post-reset rearm no write", writes, 0);
    cycle(1'b1, 16'h0200, 1'b0);
    expect_write("post-reset trigger", 9'h100, 8'h82);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
